// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: latches the fetched instruction, decodes
// add/sub/and/or/ld/sd/beq, sequences each over 3-5 states, produces the
// sign-extended immediate and counts retired instructions.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   Instruction [31:0]    instruction word, sampled in FETCH
//   ALUFlags [3:0]        datapath flags (branch resolution happens in datapath)
//   ALUControl [1:0]      00 add, 01 sub, 10 and, 11 or
//   ALUScr                0 = register SrcB, 1 = Imm
//   RegWrite, MemWrite    one-cycle write enables
//   MemToReg              writeback select (1 = memory)
//   Branch, PCWrite       branch qualifier, PC update pulse
//   Imm [BITS-1:0]        sign-extended immediate
//   Illegal               sticky unsupported-instruction flag
//   Retired [CNT_W-1:0]   retired-instruction count
//   State [2:0]           current FSM state
module multicycle_control_unit #(
  parameter int unsigned BITS  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Instruction,
  input  logic [3:0]       ALUFlags,
  output logic [1:0]       ALUControl,
  output logic             ALUScr,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             Branch,
  output logic             PCWrite,
  output logic [BITS-1:0]  Imm,
  output logic             Illegal,
  output logic [CNT_W-1:0] Retired,
  output logic [2:0]       State
);

  localparam int unsigned IMM_W = 12;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_SD, OP_BEQ, OP_ILL
  } op_e;

  state_e             state_q, state_d;
  op_e                op_c;
  logic [31:0]        ir_q;
  logic [IMM_W-1:0]   imm12_c;
  logic [BITS-1:0]    imm_q;
  logic [CNT_W-1:0]   retired_q;
  logic               last_c;
  logic [1:0]         alu_sel_c;
  logic               rd_nz_c;

  logic [1:0] alu_ctl_q, alu_ctl_d;
  logic       alu_src_q, alu_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       branch_q, branch_d;
  logic       pc_write_q, pc_write_d;
  logic       illegal_q, illegal_d;

  // Flags are consumed by the datapath; rs1 is not needed for control.
  logic unused_c;
  assign unused_c = ^{ALUFlags, ir_q[19:15]};

  // Instruction decode and raw 12-bit immediate from the latched IR.
  always_comb begin
    op_c    = OP_ILL;
    imm12_c = '0;
    unique case (ir_q[6:0])
      7'b0110011: begin
        if      (ir_q[14:12] == 3'b000 && ir_q[31:25] == 7'b0000000) op_c = OP_ADD;
        else if (ir_q[14:12] == 3'b000 && ir_q[31:25] == 7'b0100000) op_c = OP_SUB;
        else if (ir_q[14:12] == 3'b111 && ir_q[31:25] == 7'b0000000) op_c = OP_AND;
        else if (ir_q[14:12] == 3'b110 && ir_q[31:25] == 7'b0000000) op_c = OP_OR;
      end
      7'b0000011: begin
        if (ir_q[14:12] == 3'b011) op_c = OP_LD;
        imm12_c = ir_q[31:20];
      end
      7'b0100011: begin
        if (ir_q[14:12] == 3'b011) op_c = OP_SD;
        imm12_c = {ir_q[31:25], ir_q[11:7]};
      end
      7'b1100011: begin
        if (ir_q[14:12] == 3'b000) op_c = OP_BEQ;
        imm12_c = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
      end
      default: op_c = OP_ILL;
    endcase
  end

  always_comb begin
    unique case (op_c)
      OP_SUB, OP_BEQ: alu_sel_c = 2'b01;
      OP_AND:         alu_sel_c = 2'b10;
      OP_OR:          alu_sel_c = 2'b11;
      default:        alu_sel_c = 2'b00;
    endcase
  end

  assign rd_nz_c = (ir_q[11:7] != 5'd0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; last_c marks the final state of a retiring instruction.
  always_comb begin
    state_d = state_q;
    last_c  = 1'b0;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (op_c == OP_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (op_c == OP_BEQ) begin
          state_d = S_FETCH;
          last_c  = 1'b1;
        end else if (op_c == OP_LD || op_c == OP_SD) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (op_c == OP_SD) begin
          state_d = S_FETCH;
          last_c  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        last_c  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Output logic, evaluated on the upcoming state so the registered
  // outputs line up exactly with the state they belong to.
  always_comb begin
    alu_ctl_d    = 2'b00;
    alu_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    branch_d     = 1'b0;
    pc_write_d   = 1'b0;
    illegal_d    = illegal_q;
    unique case (state_d)
      S_EXEC: begin
        alu_ctl_d  = alu_sel_c;
        alu_src_d  = (op_c == OP_LD) || (op_c == OP_SD);
        branch_d   = (op_c == OP_BEQ);
        pc_write_d = (op_c == OP_BEQ);
      end
      S_MEM: begin
        alu_src_d   = 1'b1;
        mem_write_d = (op_c == OP_SD);
        pc_write_d  = (op_c == OP_SD);
      end
      S_WB: begin
        alu_ctl_d    = alu_sel_c;
        alu_src_d    = (op_c == OP_LD);
        mem_to_reg_d = (op_c == OP_LD);
        reg_write_d  = rd_nz_c;
        pc_write_d   = 1'b1;
      end
      S_TRAP:  illegal_d = 1'b1;
      default: ;
    endcase
  end

  // Output, IR, immediate and retire-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctl_q    <= 2'b00;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      illegal_q    <= 1'b0;
      ir_q         <= '0;
      imm_q        <= '0;
      retired_q    <= '0;
    end else begin
      alu_ctl_q    <= alu_ctl_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      branch_q     <= branch_d;
      pc_write_q   <= pc_write_d;
      illegal_q    <= illegal_d;
      if (state_q == S_FETCH)  ir_q  <= Instruction;
      if (state_q == S_DECODE) imm_q <= {{(BITS-IMM_W){imm12_c[IMM_W-1]}}, imm12_c};
      if (last_c)              retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign ALUControl = alu_ctl_q;
  assign ALUScr     = alu_src_q;
  assign RegWrite   = reg_write_q;
  assign MemWrite   = mem_write_q;
  assign MemToReg   = mem_to_reg_q;
  assign Branch     = branch_q;
  assign PCWrite    = pc_write_q;
  assign Imm        = imm_q;
  assign Illegal    = illegal_q;
  assign Retired    = retired_q;
  assign State      = state_q;

endmodule
